// File: rtl/rv32_bram_pkg.sv
// rv32_bram_pkg: shared state encoding and byte width for the rv32 block RAM
package rv32_bram_pkg;
  typedef enum logic {BRAM_CLEAR, BRAM_READY} bram_state_e;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/rv32_bram_array.sv
// rv32_bram_array: unreset storage with byte-enable synchronous write and registered read
module rv32_bram_array
  import rv32_bram_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 8
) (
  input  logic                        clk,
  input  logic [WORD_SIZE/BYTE_W-1:0] we,
  input  logic [ADDR_SIZE-1:0]        waddr,
  input  logic [WORD_SIZE-1:0]        wdata,
  input  logic                        re,
  input  logic [ADDR_SIZE-1:0]        raddr,
  output logic [WORD_SIZE-1:0]        q
);
  logic [WORD_SIZE-1:0] mem [2**ADDR_SIZE];
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_SIZE/BYTE_W; i++)
      if (we[i]) mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/rv32_bram_sdp.sv
// rv32_bram_sdp: SDP BRAM with byte enables, write-first bypass, clear-after-reset; RV32_BRAM_OUTREG_EN adds an output stage
module rv32_bram_sdp
  import rv32_bram_pkg::*;
#(
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_SIZE      = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        ready,
  input  logic                        wr_en,
  input  logic [WORD_SIZE/BYTE_W-1:0] wr_be,
  input  logic [ADDR_SIZE-1:0]        wr_addr,
  input  logic [WORD_SIZE-1:0]        wr_data,
  input  logic                        rd_en,
  input  logic [ADDR_SIZE-1:0]        rd_addr,
  output logic                        rd_valid,
  output logic [WORD_SIZE-1:0]        rd_data
);
  localparam int NB = WORD_SIZE / BYTE_W;
  localparam logic [ADDR_SIZE:0] LAST = (ADDR_SIZE+1)'(2**ADDR_SIZE - 1);
  localparam bram_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? BRAM_CLEAR : BRAM_READY;
  if (WORD_SIZE % BYTE_W != 0) begin : g_width_chk
    $error("WORD_SIZE must be a multiple of 8");
  end
  bram_state_e state, state_n;
  logic [ADDR_SIZE:0] cnt;
  logic acc_wr, acc_rd, clearing, v1, seen;
  logic [NB-1:0] arr_we, bp_mask;
  logic [ADDR_SIZE-1:0] arr_waddr;
  logic [WORD_SIZE-1:0] arr_wdata, q, bp_data, merged, rd_int;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RST_STATE;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (clearing) cnt <= cnt + 1'b1;
    end
  always_comb state_n = (state == BRAM_CLEAR && cnt == LAST) ? BRAM_READY : state;
  always_comb begin
    ready = state == BRAM_READY;
    clearing = state == BRAM_CLEAR;
  end
  assign acc_wr = wr_en && ready;
  assign acc_rd = rd_en && ready;
  always_comb begin
    arr_we = clearing ? '1 : (acc_wr ? wr_be : '0);
    arr_waddr = clearing ? cnt[ADDR_SIZE-1:0] : wr_addr;
    arr_wdata = clearing ? '0 : wr_data;
  end
  rv32_bram_array #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_array (
    .clk(clk), .we(arr_we), .waddr(arr_waddr), .wdata(arr_wdata),
    .re(acc_rd), .raddr(rd_addr), .q(q)
  );
  // the array reads old contents on a collision; bytes being written are patched in here
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      seen <= 1'b0;
      bp_mask <= '0;
      bp_data <= '0;
    end else begin
      v1 <= acc_rd;
      if (acc_rd) begin
        seen <= 1'b1;
        bp_mask <= (acc_wr && wr_addr == rd_addr) ? wr_be : '0;
        bp_data <= wr_data;
      end
    end
  for (genvar g = 0; g < NB; g++) begin : g_merge
    assign merged[g*BYTE_W +: BYTE_W] = bp_mask[g] ? bp_data[g*BYTE_W +: BYTE_W] : q[g*BYTE_W +: BYTE_W];
  end
  assign rd_int = seen ? merged : '0;
`ifdef RV32_BRAM_OUTREG_EN
  logic v2;
  logic [WORD_SIZE-1:0] d2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v2 <= 1'b0;
      d2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) d2 <= rd_int;
    end
  assign rd_valid = v2;
  assign rd_data = d2;
`else
  assign rd_valid = v1;
  assign rd_data = rd_int;
`endif
endmodule

// File: tb/tb_rv32_bram_sdp.sv
// tb_rv32_bram_sdp: directed plus random checks of rv32_bram_sdp against a word-array reference model
module tb_rv32_bram_sdp;
`ifdef RV32_BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst_n = 1'b0, ready, wr_en = 1'b0, rd_en = 1'b0, rd_valid;
  logic [3:0] wr_be = '0, wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0, rd_data;
  int total = 0, bad = 0;
  logic [31:0] mem_m [16];
  logic rdy_m;
  int clr_m;
  logic pv [2];
  logic [31:0] pd [2];
  logic [31:0] hold;
  rv32_bram_sdp #(.WORD_SIZE(32), .ADDR_SIZE(4), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .wr_en(wr_en), .wr_be(wr_be),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    rdy_m = 1'b0;
    clr_m = 0;
    hold = '0;
    for (int i = 0; i < 2; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
  endtask
  task automatic step(input logic w, input logic [3:0] be, input logic [3:0] wa, input logic [31:0] wd,
                      input logic r, input logic [3:0] ra);
    logic nv;
    logic [31:0] nd;
    wr_en = w; wr_be = be; wr_addr = wa; wr_data = wd; rd_en = r; rd_addr = ra;
    nv = r && rdy_m;
    nd = mem_m[ra];
    for (int i = 0; i < 4; i++) begin
      if (nv && w && wa == ra && be[i]) nd[i*8 +: 8] = wd[i*8 +: 8];
      if (rdy_m && w && be[i]) mem_m[wa][i*8 +: 8] = wd[i*8 +: 8];
    end
    if (!rdy_m) begin
      clr_m++;
      if (clr_m == 16) rdy_m = 1'b1;
    end
    pv[1] = pv[0]; pd[1] = pd[0]; pv[0] = nv; pd[0] = nd;
    @(posedge clk); #1;
    if (pv[LAT-1]) hold = pd[LAT-1];
    chk("ready", {31'b0, ready}, {31'b0, rdy_m});
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, pv[LAT-1]});
    chk("rd_data", rd_data, hold);
  endtask
  task automatic idle();
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask
  task automatic hit_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_hold", {31'b0, ready}, 32'h0);
    rst_n = 1'b1;
  endtask
  task automatic clear_phase(input int abort_at);
    int n = 0;
    while (!ready && n < 40 && (abort_at < 0 || n < abort_at)) begin
      step(1'($urandom), 4'($urandom), 4'($urandom), 32'($urandom) | 32'h1, 1'($urandom), 4'($urandom));
      n++;
    end
    if (abort_at < 0) chk("clear_cycles", n, 16);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por_ready", {31'b0, ready}, 32'h0);
    chk("por_rd_valid", {31'b0, rd_valid}, 32'h0);
    rst_n = 1'b1;
    clear_phase(-1);
    for (int a = 0; a < 16; a++) step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
    repeat (LAT) idle();
    step(1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, 4'h0);
    step(1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0, 4'h0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
    repeat (LAT-1) idle();
    chk("byte_enable", rd_data, 32'hDE22BE44);
    step(1'b1, 4'hF, 4'd5, 32'hAAAAAAAA, 1'b0, 4'h0);
    step(1'b1, 4'h3, 4'd5, 32'h12345678, 1'b1, 4'd5);
    repeat (LAT-1) idle();
    chk("bypass", rd_data, 32'hAAAA5678);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5);
    repeat (LAT-1) idle();
    chk("after_bypass", rd_data, 32'hAAAA5678);
    step(1'b1, 4'hF, 4'd0, 32'h01010101, 1'b0, 4'h0);
    step(1'b1, 4'hF, 4'd1, 32'h02020202, 1'b0, 4'h0);
    step(1'b1, 4'hF, 4'd2, 32'h03030303, 1'b0, 4'h0);
    for (int a = 0; a < 3; a++) step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
    repeat (LAT) idle();
    for (int k = 0; k < 300; k++)
      step(1'($urandom), 4'($urandom), 4'($urandom_range(0, 7)), $urandom, 1'($urandom), 4'($urandom_range(0, 7)));
    repeat (LAT) idle();
    hit_reset();
    clear_phase(7);
    hit_reset();
    clear_phase(-1);
    for (int a = 0; a < 16; a++) step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
    repeat (LAT) idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32_bram_sdp.md
Name: rv32_bram_sdp

Overview:
- Parametrised simple-dual-port block RAM for the multicycle core: one write channel, one read channel, one clock.
- Adds what the plain BRAM lacks:
  - per-byte write enables;
  - write-first bypass when a read and a write hit the same address in the same cycle;
  - a read-valid strobe;
  - a post-reset clear sequencer, so contents are deterministic once the RAM reports ready.
- Used as instruction/data scratch memory behind the load/store unit.

Parameters:
- WORD_SIZE, 32: data width in bits; must be a multiple of 8 (elaboration-time assertion).
- ADDR_SIZE, 8: address width; depth = 2**ADDR_SIZE words.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset; 0 = skip clearing and go ready immediately.

Ports:
- clk, input, 1: single clock for all logic.
- rst_n, input, 1: reset, asynchronous and active-low.
- ready, output, 1: high when the RAM accepts requests.
- wr_en, input, 1: write request.
- wr_be, input, WORD_SIZE/8: byte enables; bit i covers wr_data[8i+7:8i].
- wr_addr, input, ADDR_SIZE: write address.
- wr_data, input, WORD_SIZE: write data.
- rd_en, input, 1: read request.
- rd_addr, input, ADDR_SIZE: read address.
- rd_valid, output, 1: rd_data is valid this cycle (one-cycle pulse per accepted read).
- rd_data, output, WORD_SIZE: read data; holds its last value between reads.

Behaviour:
- Reset (async assert, sync release), output values:
  - ready=0, rd_valid=0, rd_data=0;
  - clear counter=0;
  - state=CLEAR if CLEAR_ON_RESET=1, else READY.
- The storage array itself has no reset, so BRAM inference is preserved.
- State CLEAR:
  - writes 0 to the address given by the counter each cycle, with all bytes enabled;
  - the counter increments each cycle;
  - after writing address 2**ADDR_SIZE-1, goes to READY on the next edge;
  - clearing takes exactly 2**ADDR_SIZE cycles;
  - ready=0 throughout.
- State READY:
  - ready=1;
  - no exit except reset.
- Reset asserted mid-CLEAR: the counter returns to 0 and clearing restarts from address 0 after release.
- Requests while ready=0: wr_en and rd_en are ignored; no array write from the user port; rd_valid stays 0.
- Write, in READY with wr_en=1: at the clock edge, each byte i with wr_be[i]=1 is updated. wr_be=0 changes nothing.
- Read, in READY with rd_en=1:
  - rd_valid=1 and rd_data=mem[rd_addr] on the following cycle (latency 1);
  - rd_valid deasserts the cycle after if rd_en was low.
- Back-to-back reads: one read per cycle, no bubbles.
- Same-cycle read and write to the same address (wr_en && rd_en && wr_addr==rd_addr):
  - write-first per byte: rd_data byte i = wr_data byte i if wr_be[i]=1, else the old mem byte;
  - the array is updated normally.
- Same-cycle read and write to different addresses: independent; the read returns old contents.
- Read the cycle after a write to the same address returns the new data; no special case.
- Address wrap: addresses are exactly ADDR_SIZE bits, so there is no out-of-range case.
- The clear counter is ADDR_SIZE+1 bits wide so the terminal count is detectable.
- There is no response backpressure; the consumer must sample rd_data when rd_valid=1.

Optional Feature:
- RV32_BRAM_OUTREG_EN defined:
  - one extra output register stage; read latency 2;
  - rd_valid is pipelined alongside the data;
  - bypass is resolved in the request cycle, so a write one cycle after the read is not forwarded;
  - reset value of the extra stage is 0/invalid.
- Not defined: latency 1 as above.

Decomposition:
- Package rv32_bram_pkg:
  - typedef enum logic {BRAM_CLEAR, BRAM_READY} bram_state_e;
  - localparam BYTE_W = 8.
- Sub-module rv32_bram_array: raw storage with byte-enable synchronous write and synchronous read, no reset.
- The top level holds the clear FSM, request gating, the bypass mux and the optional output stage.

Test Plan:
- Clear: ADDR_SIZE=4, CLEAR_ON_RESET=1.
  - Release rst_n, then count cycles → ready rises exactly 16 cycles after release.
  - Read all 16 addresses → all 0x00000000, with rd_valid one cycle after each rd_en.
- Byte enables:
  - Write 0xDEADBEEF to addr 3 with be=4'b1111, then 0x11223344 with be=4'b0101.
  - Read addr 3 → 0xDE22BE44.
- Bypass:
  - mem[5]=0xAAAAAAAA; same cycle: wr_en, addr 5, data 0x12345678, be=4'b0011, and rd_en, addr 5.
  - rd_data → 0xAAAA5678; a later read of addr 5 → 0xAAAA5678.
- Gating: drive rd_en and wr_en during CLEAR → rd_valid never asserts; memory stays zero afterwards.
- Reset mid-clear:
  - Assert rst_n low at clear cycle 7, release → ready after a full 16 cycles; ready=0, rd_valid=0 while in reset.
- With RV32_BRAM_OUTREG_EN: back-to-back reads of addrs 0,1,2 → rd_valid high for 3 cycles, starting 2 cycles after the first rd_en, with data in order.
